// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide sequencer: FSM states, latched op, Hi/Lo source selects.
package muldiv_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned DATA_W  = 32;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE      = 3'd0,
    S_MULT_RUN  = 3'd1,
    S_DIV_CHECK = 3'd2,
    S_DIV_RUN   = 3'd3,
    S_WRITE     = 3'd4,
    S_DONE      = 3'd5,
    S_DZERO     = 3'd6
  } state_t;

  typedef enum logic {
    OP_DIV  = 1'b0,
    OP_MULT = 1'b1
  } op_t;

  localparam logic SRC_DIV  = 1'b0;
  localparam logic SRC_MULT = 1'b1;

  // Hi/Lo mux select that matches the unit which produced the result
  function automatic logic src_for_op(input op_t op);
    return (op == OP_MULT) ? SRC_MULT : SRC_DIV;
  endfunction

endpackage

// File: rtl/muldiv_cycle_counter.sv
// Loadable down-counter; zero is registered alongside the count so it is glitch-free.
module muldiv_cycle_counter #(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] r_count;
  logic             r_zero;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_zero  <= 1'b1;
    end else if (load) begin
      r_count <= load_val;
      r_zero  <= (load_val == '0);
    end else if (en && !r_zero) begin
      r_count <= r_count - CNT_W'(1);
      r_zero  <= (r_count == CNT_W'(1));
    end
  end

  assign zero = r_zero;

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequences multiplier/divider runs for control_unit: run enables, divisor-zero check and Hi/Lo write-back.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 32,
  parameter int unsigned DIV_CYCLES  = 32,
  parameter int unsigned CNT_W       = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mult_req,
  input  logic              div_req,
  input  logic              div_srcA_req,
  input  logic              div_srcB_req,
  input  logic [DATA_W-1:0] divisor,
  output logic              MULT_on,
  output logic              DIV_on,
  output logic              div_srcA,
  output logic              div_srcB,
  output logic              Hi_write,
  output logic              Lo_write,
  output logic              Hi_src,
  output logic              Lo_src,
  output logic              busy,
  output logic              done,
  output logic              div_zero
);

  state_t           r_state;
  state_t           w_next;
  op_t              r_op;
  op_t              w_op;
  logic             r_div_srca;
  logic             r_div_srcb;
  logic             w_div_srca;
  logic             w_div_srcb;
  logic             r_mult_on;
  logic             r_div_on;
  logic             r_hilo_write;
  logic             r_hilo_src;
  logic             w_hilo_src;
  logic             r_busy;
  logic             r_done;
  logic             r_div_zero;
  logic             w_cnt_load;
  logic             w_cnt_en;
  logic [CNT_W-1:0] w_cnt_val;
  logic             w_cnt_zero;

  muldiv_cycle_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (w_cnt_load),
    .load_val (w_cnt_val),
    .en       (w_cnt_en),
    .zero     (w_cnt_zero)
  );

  // Next-state, counter control and latched-operand selection
  always_comb begin
    w_next      = r_state;
    w_op        = r_op;
    w_div_srca  = r_div_srca;
    w_div_srcb  = r_div_srcb;
    w_cnt_load  = 1'b0;
    w_cnt_en    = 1'b0;
    w_cnt_val   = '0;
    w_hilo_src  = r_hilo_src;
    case (r_state)
      S_IDLE: begin
        if (mult_req) begin
          w_next     = S_MULT_RUN;
          w_op       = OP_MULT;
          w_cnt_load = 1'b1;
          w_cnt_val  = CNT_W'(MULT_CYCLES - 1);
        end else if (div_req) begin
          w_next     = S_DIV_CHECK;
          w_op       = OP_DIV;
          w_div_srca = div_srcA_req;
          w_div_srcb = div_srcB_req;
        end
      end
      S_MULT_RUN: begin
        w_cnt_en = 1'b1;
        if (w_cnt_zero) w_next = S_WRITE;
      end
      S_DIV_CHECK: begin
        if (divisor == '0) begin
          w_next = S_DZERO;
        end else begin
          w_next     = S_DIV_RUN;
          w_cnt_load = 1'b1;
          w_cnt_val  = CNT_W'(DIV_CYCLES - 1);
        end
      end
      S_DIV_RUN: begin
        w_cnt_en = 1'b1;
        if (w_cnt_zero) w_next = S_WRITE;
      end
      S_WRITE: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      S_DZERO: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (w_next == S_WRITE) w_hilo_src = src_for_op(r_op);
  end

  // State plus outputs registered from the state being entered
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_op         <= OP_DIV;
      r_div_srca   <= 1'b0;
      r_div_srcb   <= 1'b0;
      r_mult_on    <= 1'b0;
      r_div_on     <= 1'b0;
      r_hilo_write <= 1'b0;
      r_hilo_src   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_div_zero   <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_op         <= w_op;
      r_div_srca   <= w_div_srca;
      r_div_srcb   <= w_div_srcb;
      r_mult_on    <= (w_next == S_MULT_RUN);
      r_div_on     <= (w_next == S_DIV_RUN);
      r_hilo_write <= (w_next == S_WRITE);
      r_hilo_src   <= w_hilo_src;
      r_busy       <= (w_next != S_IDLE);
      r_done       <= (w_next == S_DONE);
      r_div_zero   <= (w_next == S_DZERO);
    end
  end

  assign MULT_on  = r_mult_on;
  assign DIV_on   = r_div_on;
  assign div_srcA = r_div_srca;
  assign div_srcB = r_div_srcb;
  assign Hi_write = r_hilo_write;
  assign Lo_write = r_hilo_write;
  assign Hi_src   = r_hilo_src;
  assign Lo_src   = r_hilo_src;
  assign busy     = r_busy;
  assign done     = r_done;
  assign div_zero = r_div_zero;

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Sequences the multiplier and divider on behalf of control_unit, which issues one-cycle mult/div requests and then waits.
- Owns all control of those units: the start/run enables (MULT_on/DIV_on), the divider operand-source selects, cycle counting, the divide-by-zero check, and the Hi/Lo write-back (Hi_write, Lo_write, Hi_src, Lo_src).
- Frees control_unit from per-cycle counting during long arithmetic operations.

Parameters:
- MULT_CYCLES, 32, number of cycles MULT_on is held high per multiply.
- DIV_CYCLES, 32, number of cycles DIV_on is held high per divide.
- CNT_W, 6, counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- mult_req  in  1  one-cycle multiply request from control_unit.
- div_req  in  1  one-cycle divide request from control_unit.
- div_srcA_req  in  1  dividend source select; latched when a div_req is accepted.
- div_srcB_req  in  1  divisor source select; latched when a div_req is accepted.
- divisor  in  32  output of the div_srcB mux; sampled in DIV_CHECK.
- MULT_on  out  1  multiplier run enable.
- DIV_on  out  1  divider run enable.
- div_srcA  out  1  latched dividend select, held stable for the whole divide.
- div_srcB  out  1  latched divisor select, held stable for the whole divide.
- Hi_write  out  1  Hi register load strobe.
- Lo_write  out  1  Lo register load strobe.
- Hi_src  out  1  Hi mux select: 0 = divider, 1 = multiplier.
- Lo_src  out  1  Lo mux select: 0 = divider, 1 = multiplier.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- div_zero  out  1  one-cycle divide-by-zero exception pulse.

Behaviour:
- Reset:
  - Takes effect at any clk edge with reset=1, including mid-operation.
  - Forces state to IDLE and the counter to 0.
  - Drives all outputs to 0.
  - An in-flight operation is abandoned; no Hi/Lo write occurs.
- States: IDLE, MULT_RUN, DIV_CHECK, DIV_RUN, WRITE, DONE, DZERO.
- IDLE:
  - mult_req=1: go to MULT_RUN; counter = MULT_CYCLES-1; latch op = MULT.
  - else div_req=1: go to DIV_CHECK; latch op = DIV; latch div_srcA/div_srcB from the *_req inputs.
  - Both requests in the same cycle: multiply wins; div_req is dropped.
- Requests in any state other than IDLE are ignored and not queued.
- MULT_RUN:
  - MULT_on=1 for exactly MULT_CYCLES cycles.
  - Counter decrements each cycle; at counter==0 go to WRITE.
- DIV_CHECK (1 cycle):
  - div_src outputs are already valid, so divisor is meaningful this cycle.
  - divisor==0: go to DZERO.
  - Otherwise: go to DIV_RUN; counter = DIV_CYCLES-1.
- DIV_RUN:
  - DIV_on=1 for exactly DIV_CYCLES cycles; then go to WRITE.
- WRITE (1 cycle):
  - Hi_write = Lo_write = 1.
  - Hi_src = Lo_src = 1 if op==MULT, 0 if op==DIV.
  - Next state DONE.
- DONE (1 cycle): done=1, then IDLE.
- DZERO (1 cycle):
  - div_zero=1; done stays 0; Hi and Lo are not written.
  - Next state IDLE.
- Output holding:
  - Hi_src/Lo_src hold their last-driven value outside WRITE.
  - div_srcA/div_srcB hold until the next accepted div_req.
- MULT_on and DIV_on are never high simultaneously.
- Latency, counted from the accepting edge E0:
  - Multiply: done high during cycle MULT_CYCLES+2 (32 cycles of MULT_ON, then WRITE, then DONE).
  - Divide: done high during cycle DIV_CYCLES+3.
  - Divide by zero: div_zero high during cycle 2.
- busy is 0 in IDLE and 1 in all other states, including DONE and DZERO.

Decomposition:
- Package muldiv_pkg holds:
  - state encoding localparams (3-bit): S_IDLE, S_MULT_RUN, S_DIV_CHECK, S_DIV_RUN, S_WRITE, S_DONE, S_DZERO;
  - op encodings OP_MULT, OP_DIV;
  - Hi/Lo select encodings SRC_DIV=0, SRC_MULT=1.
- One sub-module, muldiv_cycle_counter:
  - loadable down-counter of width CNT_W;
  - ports: clk, reset, load, load_val, en, zero.

Test Plan:
- Reset, then idle 5 cycles → all outputs 0, busy=0.
- mult_req pulse → MULT_ON high exactly 32 cycles; WRITE cycle with Hi_write=Lo_write=1 and Hi_src=Lo_src=1; done pulse at cycle 34; busy back to 0 at cycle 35.
- div_req with div_srcA_req=1, div_srcB_req=0, divisor=7 → div_srcA=1 and div_srcB=0 held throughout; DIV_on high 32 cycles; Hi_src=Lo_src=0 in WRITE; done at cycle 35.
- div_req with divisor=0 → div_zero=1 at cycle 2; Hi_write, Lo_write, done and DIV_on all stay 0; back to IDLE.
- mult_req and div_req in the same cycle, then div_req again 10 cycles later → multiply runs; DIV_on never asserts; second request ignored; exactly one done.
- reset asserted at cycle 15 of a divide → next cycle state IDLE, all outputs 0, no Hi/Lo write; a fresh mult_req then completes normally.
